// File: rtl/vga_pixel_arbiter_if.sv
// Pixel-source and vga_adapter-side signals of the vga_pixel_arbiter.
// slave = arbiter side, master = requester/adapter side.
interface vga_pixel_arbiter_if;
  logic       r0_valid, r1_valid, r2_valid;
  logic [8:0] r0_x, r1_x, r2_x;
  logic [7:0] r0_y, r1_y, r2_y;
  logic [8:0] r0_color, r1_color, r2_color;
  logic       r0_lock, r1_lock, r2_lock;
  logic       r0_ready, r1_ready, r2_ready;

  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [8:0]  vga_color;
  logic        vga_write;
  logic [1:0]  owner;
  logic [15:0] clip_count;

  modport slave (
    input  r0_valid, r1_valid, r2_valid,
    input  r0_x, r1_x, r2_x,
    input  r0_y, r1_y, r2_y,
    input  r0_color, r1_color, r2_color,
    input  r0_lock, r1_lock, r2_lock,
    output r0_ready, r1_ready, r2_ready,
    output vga_x, vga_y, vga_color, vga_write, owner, clip_count
  );

  modport master (
    output r0_valid, r1_valid, r2_valid,
    output r0_x, r1_x, r2_x,
    output r0_y, r1_y, r2_y,
    output r0_color, r1_color, r2_color,
    output r0_lock, r1_lock, r2_lock,
    input  r0_ready, r1_ready, r2_ready,
    input  vga_x, vga_y, vga_color, vga_write, owner, clip_count
  );
endinterface

// File: rtl/vga_pixel_arbiter.sv
// Shares the vga_adapter pixel-write port among three sources with lockable bursts.
// Define VGA_PIXEL_ARBITER_CLIP_EN to drop and count off-screen pixels.
//
// state     | meaning
// ST_ARB    | no owner (owner = 3); round-robin or fixed-priority grant
// ST_LOCKED | owner_q holds the port; only that requester can be granted
module vga_pixel_arbiter #(
  parameter int unsigned SCREEN_WIDTH  = 320,
  parameter int unsigned SCREEN_HEIGHT = 240,
  parameter bit          ROUND_ROBIN   = 1'b1
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  vga_pixel_arbiter_if.slave   pix
);

`ifdef VGA_PIXEL_ARBITER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [0:0] {ST_ARB, ST_LOCKED} state_t;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [8:0]  vga_x_q, vga_x_d;
  logic [7:0]  vga_y_q, vga_y_d;
  logic [8:0]  vga_color_q, vga_color_d;
  logic        vga_write_q, vga_write_d;
  logic [15:0] clip_count_q, clip_count_d;

  logic [2:0]  valid, lock, ready;
  logic [8:0]  x_in     [3];
  logic [7:0]  y_in     [3];
  logic [8:0]  color_in [3];

  logic        gnt;
  logic [1:0]  gnt_idx;
  logic [1:0]  cand;
  logic [8:0]  sel_x, sel_color;
  logic [7:0]  sel_y;
  logic        sel_lock;
  logic        clipped;

  assign valid       = {pix.r2_valid, pix.r1_valid, pix.r0_valid};
  assign lock        = {pix.r2_lock, pix.r1_lock, pix.r0_lock};
  assign x_in[0]     = pix.r0_x;
  assign x_in[1]     = pix.r1_x;
  assign x_in[2]     = pix.r2_x;
  assign y_in[0]     = pix.r0_y;
  assign y_in[1]     = pix.r1_y;
  assign y_in[2]     = pix.r2_y;
  assign color_in[0] = pix.r0_color;
  assign color_in[1] = pix.r1_color;
  assign color_in[2] = pix.r2_color;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Grant depends only on valid, state/owner and pointer, never on ready.
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = 2'd0;
    cand    = ptr_q;
    ready   = 3'b000;
    if (reset_n) begin
      if (state_q == ST_LOCKED) begin
        gnt     = valid[owner_q];
        gnt_idx = owner_q;
      end else if (ROUND_ROBIN) begin
        for (int i = 0; i < 3; i++) begin
          if (!gnt && valid[cand]) begin
            gnt     = 1'b1;
            gnt_idx = cand;
          end
          cand = inc3(cand);
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (!gnt && valid[i]) begin
            gnt     = 1'b1;
            gnt_idx = 2'(i);
          end
        end
      end
      if (gnt) ready[gnt_idx] = 1'b1;
    end
  end

  assign sel_x     = x_in[gnt_idx];
  assign sel_y     = y_in[gnt_idx];
  assign sel_color = color_in[gnt_idx];
  assign sel_lock  = lock[gnt_idx];
  assign clipped   = CLIP_EN && ((32'(sel_x) >= SCREEN_WIDTH) || (32'(sel_y) >= SCREEN_HEIGHT));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_color_d  = vga_color_q;
    vga_write_d  = 1'b0;
    clip_count_d = clip_count_q;
    if (gnt) begin
      // Clipped pixels still move the lock/pointer; they just never reach the adapter.
      if (sel_lock) begin
        state_d = ST_LOCKED;
        owner_d = gnt_idx;
      end else begin
        state_d = ST_ARB;
        owner_d = 2'd3;
      end
      ptr_d = inc3(gnt_idx);
      if (clipped) begin
        if (clip_count_q != 16'hFFFF) clip_count_d = clip_count_q + 16'd1;
      end else begin
        vga_write_d = 1'b1;
        vga_x_d     = sel_x;
        vga_y_d     = sel_y;
        vga_color_d = sel_color;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q      <= ST_ARB;
      owner_q      <= 2'd3;
      ptr_q        <= 2'd0;
      vga_x_q      <= 9'd0;
      vga_y_q      <= 8'd0;
      vga_color_q  <= 9'd0;
      vga_write_q  <= 1'b0;
      clip_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_color_q  <= vga_color_d;
      vga_write_q  <= vga_write_d;
      clip_count_q <= clip_count_d;
    end
  end

  assign pix.r0_ready   = ready[0];
  assign pix.r1_ready   = ready[1];
  assign pix.r2_ready   = ready[2];
  assign pix.vga_x      = vga_x_q;
  assign pix.vga_y      = vga_y_q;
  assign pix.vga_color  = vga_color_q;
  assign pix.vga_write  = vga_write_q;
  assign pix.owner      = owner_q;
  assign pix.clip_count = clip_count_q;

endmodule

// File: tb/tb_vga_pixel_arbiter.sv
// Directed bench for vga_pixel_arbiter: a round-robin instance and a fixed-priority instance.
module tb_vga_pixel_arbiter;
  logic CLOCK_50;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  vga_pixel_arbiter_if if_rr ();
  vga_pixel_arbiter_if if_fp ();

  vga_pixel_arbiter #(.ROUND_ROBIN(1'b1)) u_rr (.CLOCK_50(CLOCK_50), .reset_n(reset_n), .pix(if_rr.slave));
  vga_pixel_arbiter #(.ROUND_ROBIN(1'b0)) u_fp (.CLOCK_50(CLOCK_50), .reset_n(reset_n), .pix(if_fp.slave));

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] rdy_rr();
    return {if_rr.r2_ready, if_rr.r1_ready, if_rr.r0_ready};
  endfunction

  function automatic logic [2:0] rdy_fp();
    return {if_fp.r2_ready, if_fp.r1_ready, if_fp.r0_ready};
  endfunction

  task automatic set_rr(input int n, input logic v, input logic [8:0] x, input logic [7:0] y,
                        input logic [8:0] c, input logic lk);
    case (n)
      0: begin if_rr.r0_valid = v; if_rr.r0_x = x; if_rr.r0_y = y; if_rr.r0_color = c; if_rr.r0_lock = lk; end
      1: begin if_rr.r1_valid = v; if_rr.r1_x = x; if_rr.r1_y = y; if_rr.r1_color = c; if_rr.r1_lock = lk; end
      default: begin if_rr.r2_valid = v; if_rr.r2_x = x; if_rr.r2_y = y; if_rr.r2_color = c; if_rr.r2_lock = lk; end
    endcase
  endtask

  task automatic set_fp(input int n, input logic v, input logic [8:0] x);
    case (n)
      0: begin if_fp.r0_valid = v; if_fp.r0_x = x; if_fp.r0_y = 8'd1; if_fp.r0_color = 9'd0; if_fp.r0_lock = 1'b0; end
      1: begin if_fp.r1_valid = v; if_fp.r1_x = x; if_fp.r1_y = 8'd1; if_fp.r1_color = 9'd0; if_fp.r1_lock = 1'b0; end
      default: begin if_fp.r2_valid = v; if_fp.r2_x = x; if_fp.r2_y = 8'd1; if_fp.r2_color = 9'd0; if_fp.r2_lock = 1'b0; end
    endcase
  endtask

  // Inputs are set just after a rising edge; ready is sampled at the falling edge,
  // registered outputs 1 time unit after the next rising edge.
  task automatic cyc_rr(input string tag, input logic [2:0] exp_rdy);
    @(negedge CLOCK_50);
    chk(tag, 32'(rdy_rr()), 32'(exp_rdy));
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic cyc_fp(input string tag, input logic [2:0] exp_rdy);
    @(negedge CLOCK_50);
    chk(tag, 32'(rdy_fp()), 32'(exp_rdy));
    @(posedge CLOCK_50);
    #1;
  endtask

  logic       t4_v   [8];
  logic [8:0] t4_x   [8];
  logic       t4_lk  [8];
  logic [2:0] t4_rdy [8];
  logic [1:0] t4_own [8];
  logic       t4_wr  [8];
  logic [8:0] t4_ox  [8];

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      set_rr(n, 1'b0, 9'd0, 8'd0, 9'd0, 1'b0);
      set_fp(n, 1'b0, 9'd0);
    end

    // Reset with every requester valid
    @(posedge CLOCK_50);
    #1;
    for (int n = 0; n < 3; n++) set_rr(n, 1'b1, 9'(10 + n), 8'(20 + n), 9'(9'h100 + n), 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc_rr("rst_ready", 3'b000);
      chk("rst_write", 32'(if_rr.vga_write), 32'd0);
      chk("rst_owner", 32'(if_rr.owner), 32'd3);
    end
    chk("rst_x", 32'(if_rr.vga_x), 32'd0);
    chk("rst_clip", 32'(if_rr.clip_count), 32'd0);
    reset_n = 1'b1;

    // Round-robin 0,1,2,0,1,2 with one-cycle latency
    for (int i = 0; i < 6; i++) begin
      cyc_rr("rr_ready", 3'(1 << (i % 3)));
      chk("rr_write", 32'(if_rr.vga_write), 32'd1);
      chk("rr_x", 32'(if_rr.vga_x), 32'(10 + (i % 3)));
      chk("rr_y", 32'(if_rr.vga_y), 32'(20 + (i % 3)));
      chk("rr_color", 32'(if_rr.vga_color), 32'(9'h100 + (i % 3)));
    end
    for (int n = 0; n < 3; n++) set_rr(n, 1'b0, 9'd0, 8'd0, 9'd0, 1'b0);
    cyc_rr("idle_ready", 3'b000);
    chk("idle_write", 32'(if_rr.vga_write), 32'd0);
    chk("idle_hold_x", 32'(if_rr.vga_x), 32'd12);

    // Lock burst by r0 while r1 is continuously valid
    t4_v   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    t4_x   = '{9'd0, 9'd1, 9'd1, 9'd1, 9'd2, 9'd3, 9'd4, 9'd4};
    t4_lk  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    t4_rdy = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b010};
    t4_own = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3};
    t4_wr  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    t4_ox  = '{9'd0, 9'd1, 9'd1, 9'd1, 9'd2, 9'd3, 9'd4, 9'd100};
    set_rr(1, 1'b1, 9'd100, 8'd5, 9'd7, 1'b0);
    for (int c = 0; c < 8; c++) begin
      set_rr(0, t4_v[c], t4_x[c], 8'd0, 9'd3, t4_lk[c]);
      cyc_rr("lock_ready", t4_rdy[c]);
      chk("lock_owner", 32'(if_rr.owner), 32'(t4_own[c]));
      chk("lock_write", 32'(if_rr.vga_write), 32'(t4_wr[c]));
      chk("lock_x", 32'(if_rr.vga_x), 32'(t4_ox[c]));
    end
    set_rr(1, 1'b0, 9'd0, 8'd0, 9'd0, 1'b0);

    // Fixed priority
    set_fp(1, 1'b1, 9'd21);
    set_fp(2, 1'b1, 9'd22);
    for (int i = 0; i < 4; i++) begin
      cyc_fp("fp_ready_r1", 3'b010);
      chk("fp_x_r1", 32'(if_fp.vga_x), 32'd21);
      chk("fp_write", 32'(if_fp.vga_write), 32'd1);
    end
    set_fp(1, 1'b0, 9'd21);
    cyc_fp("fp_ready_r2", 3'b100);
    chk("fp_x_r2", 32'(if_fp.vga_x), 32'd22);
    set_fp(0, 1'b1, 9'd20);
    set_fp(1, 1'b1, 9'd21);
    cyc_fp("fp_ready_r0", 3'b001);
    chk("fp_x_r0", 32'(if_fp.vga_x), 32'd20);
    for (int n = 0; n < 3; n++) set_fp(n, 1'b0, 9'd0);

    // Reset in the middle of an r0 burst
    set_rr(0, 1'b1, 9'd7, 8'd2, 9'd1, 1'b1);
    cyc_rr("mid_ready_a", 3'b001);
    chk("mid_owner_a", 32'(if_rr.owner), 32'd0);
    chk("mid_x_a", 32'(if_rr.vga_x), 32'd7);
    set_rr(0, 1'b1, 9'd8, 8'd2, 9'd1, 1'b1);
    reset_n = 1'b0;
    cyc_rr("mid_ready_rst", 3'b000);
    chk("mid_write_rst", 32'(if_rr.vga_write), 32'd0);
    chk("mid_owner_rst", 32'(if_rr.owner), 32'd3);
    chk("mid_x_rst", 32'(if_rr.vga_x), 32'd0);
    reset_n = 1'b1;
    set_rr(0, 1'b0, 9'd0, 8'd0, 9'd0, 1'b0);
    set_rr(1, 1'b1, 9'd50, 8'd6, 9'd2, 1'b0);
    cyc_rr("mid_ready_r1", 3'b010);
    chk("mid_x_r1", 32'(if_rr.vga_x), 32'd50);
    chk("mid_write_r1", 32'(if_rr.vga_write), 32'd1);
    chk("mid_owner_r1", 32'(if_rr.owner), 32'd3);
    set_rr(1, 1'b0, 9'd0, 8'd0, 9'd0, 1'b0);

    // Off-screen pixels from r2
    set_rr(2, 1'b1, 9'd320, 8'd10, 9'd4, 1'b0);
    cyc_rr("clip_ready_1", 3'b100);
`ifdef VGA_PIXEL_ARBITER_CLIP_EN
    chk("clip_write_1", 32'(if_rr.vga_write), 32'd0);
    chk("clip_count_1", 32'(if_rr.clip_count), 32'd1);
    chk("clip_hold_x_1", 32'(if_rr.vga_x), 32'd50);
`else
    chk("clip_write_1", 32'(if_rr.vga_write), 32'd1);
    chk("clip_count_1", 32'(if_rr.clip_count), 32'd0);
    chk("clip_x_1", 32'(if_rr.vga_x), 32'd320);
`endif
    set_rr(2, 1'b1, 9'd5, 8'd240, 9'd4, 1'b0);
    cyc_rr("clip_ready_2", 3'b100);
`ifdef VGA_PIXEL_ARBITER_CLIP_EN
    chk("clip_write_2", 32'(if_rr.vga_write), 32'd0);
    chk("clip_count_2", 32'(if_rr.clip_count), 32'd2);
    chk("clip_hold_y_2", 32'(if_rr.vga_y), 32'd6);
`else
    chk("clip_write_2", 32'(if_rr.vga_write), 32'd1);
    chk("clip_count_2", 32'(if_rr.clip_count), 32'd0);
    chk("clip_y_2", 32'(if_rr.vga_y), 32'd240);
`endif
    set_rr(2, 1'b1, 9'd319, 8'd239, 9'd4, 1'b0);
    cyc_rr("clip_ready_3", 3'b100);
    chk("clip_write_3", 32'(if_rr.vga_write), 32'd1);
    chk("clip_x_3", 32'(if_rr.vga_x), 32'd319);
    chk("clip_y_3", 32'(if_rr.vga_y), 32'd239);
`ifdef VGA_PIXEL_ARBITER_CLIP_EN
    chk("clip_count_3", 32'(if_rr.clip_count), 32'd2);
`else
    chk("clip_count_3", 32'(if_rr.clip_count), 32'd0);
`endif
    set_rr(2, 1'b0, 9'd0, 8'd0, 9'd0, 1'b0);
    cyc_rr("end_ready", 3'b000);
    chk("end_write", 32'(if_rr.vga_write), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_pixel_arbiter.md
Name: vga_pixel_arbiter

Overview:
- Shares the single vga_adapter pixel-write port among three pixel sources.
- Sources: r0 = screen clear engine, r1 = line drawer, r2 = cursor overlay.
- Each source has a valid/ready handshake. Arbitration is round-robin or fixed-priority.
- A requester can lock the port for an uninterrupted burst, e.g. a full-screen clear. The output is registered and drives vga_x / vga_y / vga_color / vga_write directly.

Parameters:
- SCREEN_WIDTH, 320, horizontal pixel count; used only by the clip feature.
- SCREEN_HEIGHT, 240, vertical pixel count; used only by the clip feature.
- ROUND_ROBIN, 1, 1 = round-robin arbitration; 0 = fixed priority r0 > r1 > r2.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- rN_valid  in  1  requester N (N = 0, 1, 2) presents a pixel
- rN_x  in  9  pixel x, 0-319
- rN_y  in  8  pixel y, 0-239
- rN_color  in  9  RGB 3:3:3 colour
- rN_lock  in  1  with the pixel: keep ownership after this pixel
- rN_ready  out  1  combinational; pixel accepted this cycle
- vga_x  out  9  registered pixel x
- vga_y  out  8  registered pixel y
- vga_color  out  9  registered colour
- vga_write  out  1  one-cycle write strobe per accepted pixel
- owner  out  2  current lock owner: 0-2, or 3 = unlocked
- clip_count  out  16  dropped-pixel count (see Optional Feature)

Behaviour:
- Reset (reset_n = 0 at a clock edge):
  - vga_x = 0, vga_y = 0, vga_color = 0, vga_write = 0.
  - owner = 3, rr pointer = 0, clip_count = 0.
  - All rN_ready = 0 while reset_n = 0.
- Transfer rule:
  - A pixel transfers in a cycle where rN_valid and rN_ready are both 1.
  - At most one rN_ready is high per cycle.
  - rN_ready never depends on rN_ready; it is derived from valid, owner and pointer only.
- Latency: exactly 1 cycle. Accepted pixel fields appear on vga_x/y/color with vga_write = 1 on the next cycle. In any cycle with no transfer, vga_write = 0 and vga_x/y/color hold their values.
- State ARB (owner = 3):
  - ROUND_ROBIN = 1: grant the first valid requester found scanning from the pointer upward modulo 3. After granting k, pointer = (k + 1) mod 3.
  - ROUND_ROBIN = 0: grant the lowest-index valid requester; the pointer is unused.
  - Granted pixel with rN_lock = 1: go to LOCKED with owner = N.
- State LOCKED (owner = N):
  - Only requester N can be granted; other requesters see ready = 0 regardless of valid.
  - If owner drops valid, the lock is held and nothing is written.
  - A granted owner pixel with lock = 0 is written and returns to ARB (owner = 3).
  - Pointer is set to (N + 1) mod 3 on release.
- Simultaneous events:
  - Release and a new request in the same cycle: the new request is arbitrated from the next cycle.
  - A requester's first pixel, when it carries lock = 1, is granted normally and takes the lock.
- Reset mid-burst: the lock is cleared, and any pixel registered for output is discarded (vga_write = 0 in the following cycle).
- Requesters hold x/y/color/lock stable while valid = 1 and ready = 0. Violations are undefined.

Optional Feature:
- Macro: VGA_PIXEL_ARBITER_CLIP_EN.
- Defined:
  - Accepted pixels with x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT are still handshaken (ready = 1) and still update lock state.
  - They do not produce vga_write, and vga_x/y/color do not update for them.
  - clip_count increments by 1 per clipped pixel and saturates at 16'hFFFF.
- Undefined: no range check; every accepted pixel is written. clip_count is tied to 0.

Test Plan:
1. Reset: hold reset_n = 0 with all valid = 1 for 3 cycles -> all ready = 0, vga_write = 0, owner = 3. First cycle after release grants r0.
2. Round-robin: r0, r1, r2 valid continuously with lock = 0 -> grants r0, r1, r2, r0, ... on consecutive cycles; vga_write high every cycle from cycle 2 onward, vga_x matching the granted source one cycle later.
3. Fixed priority (ROUND_ROBIN = 0): r1 and r2 valid continuously -> r1 granted every cycle, r2 never; r2 granted on the first cycle r1 drops valid.
4. Lock burst:
   - Stimulus: r0 sends 5 pixels (x = 0..4, y = 0) with lock = 1,1,1,1,0, gapping valid low for 2 cycles after the 2nd pixel, while r1 is continuously valid.
   - Response: owner = 0 throughout, r1_ready stays 0 until after the 5th pixel, and r1 is granted the cycle after release.
5. Reset mid-burst: r0 locked, reset_n low for 1 cycle during a transfer -> vga_write = 0 on the next cycle and owner = 3. After reset, r1 (valid) is granted while r0 is not valid.
6. Clip (macro defined): r2 sends (320, 10), then (5, 240), then (319, 239) -> no vga_write for the first two and clip_count = 2. Third pixel written with vga_x = 319, vga_y = 239.
